prng_share_arbiter: RTL and testbench
=====================================

Name: prng_share_arbiter

Overview:
- Owns the single 16-bit LCG/permutation noise engine and time-shares it between up to 8 requesters (video noise lanes, audio noise) with a round-robin arbiter.
- One 8-bit random value is issued per grant.
- Sequences engine stepping: seed load, per-frame re-seed for stable patterns, and free-run when idle.

Parameters:
- NUM_REQ, 3, number of requesters (legal 2..8).
- SEED, 16'd4356, reset value of engine state and seed register.
- MULT, 16'd12829, LCG multiplier.
- INC, 16'd47989, LCG increment.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NUM_REQ  level request per requester.
- ack  out  NUM_REQ  one-hot, one-cycle grant/data-valid pulse.
- rnd_data  out  8  random value; valid while any ack bit is high, held otherwise.
- seed_load  in  1  pulse: load seed_in into seed register and engine state.
- seed_in  in  16  new seed.
- frame_start  in  1  pulse at frame boundary.
- frame_lock  in  1  1 = frame_start restores state from seed register.
- free_run  in  1  1 = step engine every idle cycle.
- state_out  out  16  current engine state (debug/visualisation).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state, seed_reg <= SEED; ack <= 0; rnd_data <= 0; rr pointer <= 0.
  - Reset overrides all other inputs.
- step(s) = (s*MULT + INC) mod 2^16.
- permute(s):
  - k = (s>>13) + 3, range 3..10.
  - x = ((s >> k) ^ s), 16 bits.
  - y = (x*62169) mod 2^16.
  - result = y[15:8].
- Eligibility: req[i] is eligible in a cycle only if ack[i] is low that cycle. This masks a requester during its own ack cycle so it can drop req cleanly. A req held high after that is a new request.
- Arbitration (combinational on the current cycle):
  - Search eligible requesters starting at pointer p, ascending, with wrap mod NUM_REQ.
  - The first hit g is granted. At most one grant per cycle.
- Per-cycle priority, evaluated at each clk edge:
  1. seed_load=1: seed_reg <= seed_in; state <= seed_in; no grant; ack <= 0; pointer unchanged.
  2. else frame_start=1 and frame_lock=1: state <= seed_reg; no grant; ack <= 0.
  3. else grant g exists:
     - rnd_data <= permute(state); state <= step(state).
     - ack <= onehot(g); p <= (g+1) mod NUM_REQ.
  4. else (no grant): ack <= 0; if free_run, state <= step(state), else hold. rnd_data holds.
- Latency: req sampled high in cycle t with a grant gives ack plus data in cycle t+1.
  - The value returned is permute of the pre-step state, so consecutive grants consume consecutive LCG states.
- Requests blocked by seed_load or frame_start stay pending. Nothing is dropped; req is level.
- frame_start with frame_lock=0 is ignored, and normal grant or free-run proceeds.
- Throughput:
  - All NUM_REQ requesters held high get one value every cycle in total, rotated strictly in order.
  - Because of masking, one lone requester held high gets an ack every other cycle.
- state_out = state register (registered, no extra latency).

Test Plan:
1. Reset, then req=3'b001 for one cycle -> next cycle ack=3'b001, rnd_data=8'h41, state_out=16'h70E9; the cycle after, ack=0.
2. req=3'b111 held from reset -> acks 001,010,100,001,... one per cycle. Each rnd_data equals the model permute of successive states from 16'h1104.
3. req0 held continuously, others low -> ack0 pulses every other cycle. state advances exactly once per ack when free_run=0.
4. seed_load with seed_in=16'h1104 in the same cycle as req=3'b010 -> no ack that cycle, state_out=16'h1104. Next cycle ack=3'b010 with rnd_data=8'h41.
5. frame_lock=1, frame_start after 5 grants -> state_out returns to seed_reg. The next grant repeats the first value of the frame. With frame_lock=0, state is unaffected.
6. free_run=1, no req for 4 cycles -> state advances 4 LCG steps, ack=0, rnd_data unchanged. Assert rst_n=0 mid-stream -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/prng_share_arbiter.sv
// prng_share_arbiter: a single 16-bit LCG noise engine with an output permutation,
// time-shared round-robin between NUM_REQ requesters; one 8-bit value per one-cycle ack.
module prng_share_arbiter #(
  parameter int          NUM_REQ = 3,
  parameter logic [15:0] SEED    = 16'd4356,
  parameter logic [15:0] MULT    = 16'd12829,
  parameter logic [15:0] INC     = 16'd47989
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [7:0]         rnd_data,
  input  logic               seed_load,
  input  logic [15:0]        seed_in,
  input  logic               frame_start,
  input  logic               frame_lock,
  input  logic               free_run,
  output logic [15:0]        state_out
);

  localparam int          PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] NUM_REQ_W = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  function automatic logic [15:0] lcg_step(input logic [15:0] s);
    logic [15:0] prod;
    prod = s * MULT;
    return prod + INC;
  endfunction

  // Data-dependent xorshift then odd multiply; the top byte carries the best mixing.
  function automatic logic [7:0] permute(input logic [15:0] s);
    logic [3:0]  k;
    logic [15:0] x;
    logic [15:0] y;
    k = {1'b0, s[15:13]} + 4'd3;
    x = (s >> k) ^ s;
    y = x * 16'd62169;
    return y[15:8];
  endfunction

  logic [15:0]        state_q, state_d;
  logic [15:0]        seed_q,  seed_d;
  logic [NUM_REQ-1:0] ack_q,   ack_d;
  logic [7:0]         rnd_q,   rnd_d;
  logic [PW-1:0]      ptr_q,   ptr_d;

  logic [NUM_REQ-1:0] elig_s;
  logic               grant_found_s;
  logic [PW-1:0]      grant_idx_s;

  // A requester is masked during its own ack cycle so it can drop req cleanly.
  assign elig_s = req & ~ack_q;

  // Round-robin search from the pointer, ascending with wrap.
  always_comb begin
    logic [PW:0] sum_w;
    logic [PW:0] idx_w;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_w = {1'b0, ptr_q} + (PW+1)'(i);
      idx_w = (sum_w >= NUM_REQ_W) ? (sum_w - NUM_REQ_W) : sum_w;
      if (!grant_found_s && elig_s[idx_w[PW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = idx_w[PW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Engine sequencing: seed load, then locked frame restore, then grant, then idle.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    ack_d   = '0;
    rnd_d   = rnd_q;
    ptr_d   = ptr_q;
    if (seed_load) begin
      seed_d  = seed_in;
      state_d = seed_in;
    end else if (frame_start && frame_lock) begin
      state_d = seed_q;
    end else if (grant_found_s) begin
      rnd_d   = permute(state_q);
      state_d = lcg_step(state_q);
      ack_d   = NUM_REQ'(1) << grant_idx_s;
      ptr_d   = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + PW'(1);
    end else if (free_run) begin
      state_d = lcg_step(state_q);
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
      seed_q  <= SEED;
      ack_q   <= '0;
      rnd_q   <= 8'd0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      ack_q   <= ack_d;
      rnd_q   <= rnd_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ack       = ack_q;
  assign rnd_data  = rnd_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_prng_share_arbiter.sv
// Bench for prng_share_arbiter: directed vectors with hand-computed constants plus a
// behavioural model feeding a scoreboard that a negedge monitor drains on every ack.
module tb_prng_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  ack;
  logic [7:0]  rnd_data;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        frame_start;
  logic        frame_lock;
  logic        free_run;
  logic [15:0] state_out;

  int checks   = 0;
  int failures = 0;
  int cycle_cnt = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  ack;
    logic [7:0]  rnd;
    logic [15:0] st;
  } exp_t;
  exp_t sb_q[$];

  // Behavioural model state
  int          m_state, m_seed, m_ptr;
  logic [2:0]  m_ack;
  logic [7:0]  m_rnd;

  prng_share_arbiter #(.NUM_REQ(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .rnd_data(rnd_data),
    .seed_load(seed_load), .seed_in(seed_in), .frame_start(frame_start),
    .frame_lock(frame_lock), .free_run(free_run), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic int m_step(int s);
    longint v;
    v = (longint'(s) * 64'd12829 + 64'd47989) % 64'd65536;
    return int'(v);
  endfunction

  function automatic int m_perm(int s);
    int     k;
    longint x, y;
    k = (s >> 13) + 3;
    x = longint'(((s >> k) ^ s) & 32'hFFFF);
    y = (x * 64'd62169) % 64'd65536;
    return int'(y >> 8) & 32'hFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven, then the DUT.
  task automatic tick();
    int g;
    g = -1;
    if (!rst_n) begin
      m_state = 16'h1104; m_seed = 16'h1104; m_ack = 3'b000; m_rnd = 8'h00; m_ptr = 0;
    end else if (seed_load) begin
      m_seed = int'(seed_in); m_state = int'(seed_in); m_ack = 3'b000;
    end else if (frame_start && frame_lock) begin
      m_state = m_seed; m_ack = 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        int j;
        j = (m_ptr + i) % 3;
        if (g < 0 && req[j] && !m_ack[j]) g = j;
      end
      if (g >= 0) begin
        m_rnd   = 8'(m_perm(m_state));
        m_state = m_step(m_state);
        m_ack   = 3'(1 << g);
        m_ptr   = (g + 1) % 3;
        sb_q.push_back('{cyc: cycle_cnt + 1, ack: m_ack, rnd: m_rnd, st: 16'(m_state)});
      end else begin
        m_ack = 3'b000;
        if (free_run) m_state = m_step(m_state);
      end
    end
    @(posedge clk);
    #1;
    chk("tick_state", 32'(state_out), 32'(m_state));
    chk("tick_ack", 32'(ack), 32'(m_ack));
  endtask

  // Scoreboard monitor: every presented ack must match the oldest expected grant.
  always @(negedge clk) begin
    if (ack !== 3'b000) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_ack actual=%0b expected=none", ack);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_cycle", 32'(cycle_cnt), 32'(e.cyc));
        chk("sb_ack", 32'(ack), 32'(e.ack));
        chk("sb_rnd", 32'(rnd_data), 32'(e.rnd));
        chk("sb_state", 32'(state_out), 32'(e.st));
      end
    end
  end

  initial begin
    int s0, exp_s;
    logic [7:0] rnd_hold;
    rst_n = 1'b0; req = 3'b000; seed_load = 1'b0; seed_in = 16'h0000;
    frame_start = 1'b0; frame_lock = 1'b0; free_run = 1'b0;
    tick(); tick();
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_rnd", 32'(rnd_data), 32'h0);
    chk("reset_state", 32'(state_out), 32'h1104);

    // 1: single request from reset
    rst_n = 1'b1; req = 3'b001;
    tick();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_rnd", 32'(rnd_data), 32'h41);
    chk("t1_state", 32'(state_out), 32'h70E9);
    req = 3'b000;
    tick();
    chk("t1_ack_drop", 32'(ack), 32'h0);

    // 2: all requesters held, strict rotation from reset
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 3'b111;
    tick(); chk("t2_ack0", 32'(ack), 32'b001);
    chk("t2_rnd0", 32'(rnd_data), 32'h41);
    tick(); chk("t2_ack1", 32'(ack), 32'b010);
    tick(); chk("t2_ack2", 32'(ack), 32'b100);
    tick(); chk("t2_ack3", 32'(ack), 32'b001);
    for (int i = 0; i < 4; i++) tick();

    // 3: lone requester held -> ack every other cycle, one step per ack
    req = 3'b000; tick();
    req = 3'b001;
    for (int i = 0; i < 3; i++) begin
      s0 = m_state;
      tick(); chk("t3_ack_on", 32'(ack), 32'b001);
      chk("t3_one_step", 32'(state_out), 32'(m_step(s0)));
      tick(); chk("t3_ack_off", 32'(ack), 32'b000);
      chk("t3_hold", 32'(state_out), 32'(m_step(s0)));
    end

    // 4: seed load blocks a concurrent request, which is then served
    req = 3'b010; seed_load = 1'b1; seed_in = 16'h1104;
    tick();
    chk("t4_no_ack", 32'(ack), 32'h0);
    chk("t4_state", 32'(state_out), 32'h1104);
    seed_load = 1'b0;
    tick();
    chk("t4_ack", 32'(ack), 32'b010);
    chk("t4_rnd", 32'(rnd_data), 32'h41);

    // 5: locked frame restart repeats the frame's values
    req = 3'b000; frame_lock = 1'b1; frame_start = 1'b1;
    tick();
    chk("t5_restore0", 32'(state_out), 32'h1104);
    frame_start = 1'b0; req = 3'b111;
    for (int i = 0; i < 5; i++) tick();
    frame_start = 1'b1;
    tick();
    chk("t5_restore", 32'(state_out), 32'h1104);
    chk("t5_no_ack", 32'(ack), 32'h0);
    frame_start = 1'b0;
    tick();
    chk("t5_repeat_rnd", 32'(rnd_data), 32'h41);
    req = 3'b000; tick();
    frame_lock = 1'b0; frame_start = 1'b1;
    s0 = m_state;
    tick();
    chk("t5_unlocked_hold", 32'(state_out), 32'(s0));
    req = 3'b001;
    tick();
    chk("t5_unlocked_grant", 32'(ack), 32'b001);
    frame_start = 1'b0; req = 3'b000;
    tick();

    // 6: free-run stepping while idle, then reset mid-stream
    free_run = 1'b1;
    s0 = m_state; rnd_hold = m_rnd;
    for (int i = 0; i < 4; i++) tick();
    exp_s = s0;
    for (int i = 0; i < 4; i++) exp_s = m_step(exp_s);
    chk("t6_state", 32'(state_out), 32'(exp_s));
    chk("t6_ack", 32'(ack), 32'h0);
    chk("t6_rnd_hold", 32'(rnd_data), 32'(rnd_hold));
    req = 3'b111;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_ack", 32'(ack), 32'h0);
    chk("t6_rst_rnd", 32'(rnd_data), 32'h0);
    chk("t6_rst_state", 32'(state_out), 32'h1104);
    req = 3'b000; free_run = 1'b0;
    tick();

    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
